alu_nibble_seq: RTL



---
 rtl/alu_seq_pkg.sv | 15 +
 rtl/alu_slice4.sv | 26 ++
 rtl/alu_nibble_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op encodings and sequencer states for alu_nibble_seq
package alu_seq_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_slice4.sv
// rtl/alu_slice4.sv - combinational 4-bit AND/OR/XOR/ADD slice
module alu_slice4
  import alu_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] sel,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);

  // cout is forced low for logic ops so the carry chain clears itself
  always_comb begin
    y    = 4'h0;
    cout = 1'b0;
    case (sel)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ADD:  {cout, y} = {1'b0, a} + {1'b0, b} + {4'h0, cin};
      default: y = 4'h0;
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - word-wide ALU sequencer over one 4-bit slice; optional zero flag via ALU_SEQ_ZERO_FLAG_EN
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [1:0]             op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   carry_in,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic                   zero
`endif
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       a_q, b_q, result_q, result_nxt;
  logic [1:0]         op_q;
  logic               carry_q, carry_out_q;
  logic               accept, last;
  logic [3:0]         a_nib, b_nib, slice_y;
  logic               slice_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    last         = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Nibble mux in and merge back out, selected by the running index
  always_comb begin
    a_nib      = 4'h0;
    b_nib      = 4'h0;
    result_nxt = result_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib               = a_q[4*i +: 4];
        b_nib               = b_q[4*i +: 4];
        result_nxt[4*i +: 4] = slice_y;
      end
    end
  end

  alu_slice4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .sel  (op_q),
    .cin  (carry_q),
    .y    (slice_y),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_AND;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else if (accept) begin
      a_q         <= a;
      b_q         <= b;
      op_q        <= op;
      carry_q     <= (op == OP_ADD) & carry_in;
      idx_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else if (state_q == RUN) begin
      result_q <= result_nxt;
      carry_q  <= slice_cout;
      if (last) begin
        idx_q       <= '0;
        carry_out_q <= slice_cout;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      zero_q <= 1'b0;
    else if (accept) zero_q <= 1'b0;
    else if (last)   zero_q <= (result_nxt == '0);
  end

  assign zero = zero_q;
`endif

endmodule
